// File: rtl/cursor_pkg.sv
// Shared constants and types for the button-driven pointer position generator.
package cursor_pkg;

  localparam int POS_W      = 10;
  localparam int CALC_W     = 12;
  localparam int H_RES_DEF  = 640;
  localparam int V_RES_DEF  = 480;
  localparam int MARGIN_DEF = 5;

  localparam bit CLAMP = 1'b0;
  localparam bit WRAP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    CRUISE = 2'd2
  } axis_state_e;

endpackage

// File: rtl/cursor_axis.sv
// One cursor axis: hold-to-accelerate stepping FSM plus a bounded adder that
// either clamps or wraps at [MARGIN, max].
module cursor_axis
  import cursor_pkg::*;
#(
  parameter int               MARGIN      = MARGIN_DEF,
  parameter logic [POS_W-1:0] RST_POS     = POS_W'(360),
  parameter int               ACCEL_TICKS = 16,
  parameter int               MAX_STEP    = 8,
  parameter bit               EDGE_MODE   = CLAMP
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             tick,
  input  logic             recentre,
  input  logic             inc,
  input  logic             dec,
  input  logic [POS_W-1:0] init,
  input  logic [POS_W-1:0] max,
  output logic [POS_W-1:0] pos,
  output logic             changed
);

  localparam int STEP_W = $clog2(MAX_STEP) + 2;
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  axis_state_e              state_q, state_d;
  logic [STEP_W-1:0]        step_q, step_d, move_amt;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     dec_q, dec_d;
  logic [POS_W-1:0]         pos_q, pos_d;
  logic                     do_move, dir_nz, dir_dec, reversed;
  logic signed [CALC_W-1:0] cur_s, amt_s, sum_s, max_s, min_s;

  assign dir_nz   = inc ^ dec;
  assign dir_dec  = dec & ~inc;
  assign reversed = (dir_dec != dec_q);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    hold_d   = hold_q;
    dec_d    = dec_q;
    do_move  = 1'b0;
    move_amt = '0;
    if (tick) begin
      if (recentre) begin
        state_d = IDLE;
        step_d  = STEP_W'(1);
        hold_d  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            step_d = STEP_W'(1);
            hold_d = '0;
            if (dir_nz) begin
              do_move  = 1'b1;
              move_amt = STEP_W'(1);
              hold_d   = HOLD_W'(1);
              dec_d    = dir_dec;
              state_d  = RAMP;
            end
          end
          RAMP: begin
            if (!dir_nz) begin
              state_d = IDLE;
              step_d  = STEP_W'(1);
              hold_d  = '0;
            end else if (reversed) begin
              do_move  = 1'b1;
              move_amt = STEP_W'(1);
              step_d   = STEP_W'(1);
              hold_d   = '0;
              dec_d    = dir_dec;
            end else begin
              do_move  = 1'b1;
              move_amt = step_q;
              hold_d   = hold_q + HOLD_W'(1);
            end
          end
          CRUISE: begin
            if (!dir_nz) begin
              state_d = IDLE;
              step_d  = STEP_W'(1);
              hold_d  = '0;
            end else if (reversed) begin
              do_move  = 1'b1;
              move_amt = STEP_W'(1);
              step_d   = STEP_W'(1);
              hold_d   = '0;
              dec_d    = dir_dec;
              state_d  = RAMP;
            end else begin
              do_move  = 1'b1;
              move_amt = STEP_W'(MAX_STEP);
            end
          end
          default: begin
            state_d = IDLE;
            step_d  = STEP_W'(1);
            hold_d  = '0;
          end
        endcase
        // A full run of holds at the current step doubles it; reaching the ceiling means cruise.
        if (state_d == RAMP && hold_d == HOLD_W'(ACCEL_TICKS)) begin
          hold_d = '0;
          if ((step_d << 1) >= STEP_W'(MAX_STEP)) begin
            step_d  = STEP_W'(MAX_STEP);
            state_d = CRUISE;
          end else begin
            step_d = step_d << 1;
          end
        end
      end
    end
  end

  assign cur_s = signed'(CALC_W'(pos_q));
  assign amt_s = signed'(CALC_W'(move_amt));
  assign max_s = signed'(CALC_W'(max));
  assign min_s = signed'(CALC_W'(MARGIN));
  assign sum_s = dir_dec ? (cur_s - amt_s) : (cur_s + amt_s);

  // Overshoot past a limit is discarded in both edge modes.
  always_comb begin
    pos_d = pos_q;
    if (tick && recentre) begin
      pos_d = init;
    end else if (do_move) begin
      if (sum_s > max_s) begin
        pos_d = (EDGE_MODE == WRAP) ? POS_W'(MARGIN) : max;
      end else if (sum_s < min_s) begin
        pos_d = (EDGE_MODE == WRAP) ? max : POS_W'(MARGIN);
      end else begin
        pos_d = sum_s[POS_W-1:0];
      end
    end
  end

  assign changed = tick && (pos_d != pos_q);
  assign pos     = pos_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      step_q  <= STEP_W'(1);
      hold_q  <= '0;
      dec_q   <= 1'b0;
      pos_q   <= RST_POS;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      dec_q   <= dec_d;
      pos_q   <= pos_d;
    end
  end

endmodule

// File: rtl/cursor_mover.sv
// Pointer position generator: button synchronisers, move-tick prescaler,
// four-button recentre and the two axis engines.
module cursor_mover #(
  parameter int H_RES       = cursor_pkg::H_RES_DEF,
  parameter int V_RES       = cursor_pkg::V_RES_DEF,
  parameter int MARGIN      = cursor_pkg::MARGIN_DEF,
  parameter int X_INIT      = 360,
  parameter int Y_INIT      = 200,
  parameter int TICK_DIV    = 500000,
  parameter int ACCEL_TICKS = 16,
  parameter int MAX_STEP    = 8,
  parameter bit WRAP        = cursor_pkg::CLAMP
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         btn_east,
  input  logic                         btn_west,
  input  logic                         btn_north,
  input  logic                         btn_south,
  output logic [cursor_pkg::POS_W-1:0] x_pos,
  output logic [cursor_pkg::POS_W-1:0] y_pos,
  output logic                         moving,
  output logic                         tick
);

  localparam int               POS_W = cursor_pkg::POS_W;
  localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] X_MAX = POS_W'(H_RES - 1);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_RES - 1);
  localparam logic [POS_W-1:0] X_RST = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_INIT);

  // Button bit order: {east, west, south, north}
  logic [3:0]       btn_raw, sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             moving_q, moving_d;
  logic             recentre, x_changed, y_changed;

  assign btn_raw  = {btn_east, btn_west, btn_south, btn_north};
  assign tick     = (cnt_q == LAST);
  assign cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
  assign recentre = &sync2_q;
  assign moving_d = x_changed | y_changed;
  assign moving   = moving_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      moving_q <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      moving_q <= moving_d;
    end
  end

  cursor_axis #(
    .MARGIN      (MARGIN),
    .RST_POS     (X_RST),
    .ACCEL_TICKS (ACCEL_TICKS),
    .MAX_STEP    (MAX_STEP),
    .EDGE_MODE   (WRAP)
  ) u_x (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .tick     (tick),
    .recentre (recentre),
    .inc      (sync2_q[3]),
    .dec      (sync2_q[2]),
    .init     (X_RST),
    .max      (X_MAX),
    .pos      (x_pos),
    .changed  (x_changed)
  );

  cursor_axis #(
    .MARGIN      (MARGIN),
    .RST_POS     (Y_RST),
    .ACCEL_TICKS (ACCEL_TICKS),
    .MAX_STEP    (MAX_STEP),
    .EDGE_MODE   (WRAP)
  ) u_y (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .tick     (tick),
    .recentre (recentre),
    .inc      (sync2_q[1]),
    .dec      (sync2_q[0]),
    .init     (Y_RST),
    .max      (Y_MAX),
    .pos      (y_pos),
    .changed  (y_changed)
  );

endmodule

// File: doc/cursor_mover.md
# cursor_mover

Parametrised button-driven cursor position generator for the VGA pointer overlay. It replaces the external slow "human" clock with an internal move-tick prescaler on the single system clock. It adds hold-to-accelerate stepping, configurable screen bounds, clamp or wrap edge behaviour, and four-button recentre. Its outputs feed the pointer sprite and the hit-test logic directly.

## Interface
- H_RES, 640, horizontal resolution; the x maximum is H_RES-1
- V_RES, 480, vertical resolution; the y maximum is V_RES-1
- MARGIN, 5, minimum legal coordinate on both axes
- X_INIT, 360, x value at reset and recentre
- Y_INIT, 200, y value at reset and recentre
- TICK_DIV, 500000, clk_in cycles per move tick (≥2)
- ACCEL_TICKS, 16, moves at the current step before the step doubles (≥1)
- MAX_STEP, 8, step ceiling; must be a power of two and less than the screen span
- WRAP, 0, edge mode: 0 clamps, 1 wraps to the opposite limit
- clk_in  input  1  system clock; all logic is on the rising edge
- rst_in  input  1  asynchronous, active-high reset
- btn_east, btn_west, btn_north, btn_south  input  1 each  raw button levels, asynchronous to clk_in
- x_pos  output  10  cursor x; reset value X_INIT
- y_pos  output  10  cursor y; reset value Y_INIT
- moving  output  1  high for one cycle when either coordinate changed on a tick; reset value 0
- tick  output  1  one-cycle move-tick strobe; reset value 0

## Operation
- Each button passes through a 2-FF synchroniser (reset to 0).
- The prescaler counts 0..TICK_DIV-1. tick is asserted for exactly one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
- Per-axis direction, sampled only on tick:
  - x: +1 for east only, -1 for west only, 0 for neither or both.
  - y: +1 for south only, -1 for north only, 0 for neither or both.
- Per-axis FSM, evaluated only on tick:
  - IDLE: step=1, hold=0. If dir≠0, move by 1, set hold=1, go to RAMP.
  - RAMP: if dir=0, go to IDLE. If dir reversed versus the previous move, step=1, hold=0, stay in RAMP, then move. Otherwise move by step and increment hold. When hold reaches ACCEL_TICKS, double the step and clear hold. When the step reaches MAX_STEP, go to CRUISE.
  - CRUISE: move by MAX_STEP. dir=0 returns to IDLE; a reversal returns to RAMP with step=1.
- Arithmetic is 12-bit signed: next = pos ± step.
  - Clamp mode (WRAP=0): next > max gives max; next < MARGIN gives MARGIN.
  - Wrap mode (WRAP=1): next > max gives MARGIN; next < MARGIN gives max. The overshoot is discarded.
- A clamp does not reset the FSM or the step.
- Recentre: if all four synchronised buttons are high on a tick, x_pos=X_INIT and y_pos=Y_INIT, both FSMs go to IDLE, and no move is applied. Recentre has priority over movement.
- moving = (new x ≠ old x) or (new y ≠ old y) on that tick. A move fully absorbed by a clamp does not raise moving.

## Timing
- Button-to-sync latency is 2 cycles. Positions update on the cycle tick is high and are visible on the following cycle.
- Worst-case latency from press to first move is 2 + TICK_DIV cycles.
- moving is registered alongside the positions. It is high for exactly one cycle and is always coincident with the post-tick cycle.
- rst_in asserted at any point, including mid-ramp or on a tick cycle, immediately forces:
  - x_pos=X_INIT, y_pos=Y_INIT
  - prescaler=0, both FSMs IDLE with step=1
  - moving=0, tick=0, synchronisers cleared
- After rst_in deasserts, the first tick occurs TICK_DIV cycles later.
- Positions never hold a value outside [MARGIN, max], including at reset.

## Structure
- Package cursor_pkg holds:
  - the POS_W=10 constant
  - the default H_RES/V_RES/MARGIN values
  - the axis state enum IDLE/RAMP/CRUISE
  - the edge-mode constants CLAMP=0, WRAP=1
- Sub-module cursor_axis, instantiated twice, contains one FSM, step/hold counters and the bounded adder. Ports: clk_in, rst_in, tick, recentre, inc, dec, init, max, pos, changed.
- The top level holds the synchronisers, prescaler, recentre detect and the moving OR.

## Test plan
Unless stated, all scenarios use TICK_DIV=4, ACCEL_TICKS=3, MAX_STEP=4.
- Reset mid-ramp: hold east for 5 ticks, pulse rst_in asynchronously between edges -> x_pos=360, y_pos=200 and moving=0 immediately; the next east tick moves x by 1.
- Acceleration: hold east from reset for 8 ticks -> x sequence 361, 362, 363, 365, 367, 369, 373, 377; FSM in CRUISE after the 6th tick.
- Clamp: start at x=7, hold west -> 6, 5, 5; moving is high on the first two ticks and low on the third.
- Opposites and reversal: east+west together for 2 ticks -> x unchanged and FSM IDLE. During a ramp at step 2, switch to west -> the next move is -1.
- Wrap (WRAP=1): x=637 in CRUISE with east held -> the next tick gives x=5; x=6 with west at step 4 -> x=639.
- Recentre: from x=100, y=400, press all four buttons for 1 tick -> x=360, y=200, moving=1, both FSMs IDLE.
